// File: rtl/ov7670_config_seq_pkg.sv
// Shared constants and state encoding for the OV7670 register-init sequencer.
// The SCCB write id is consumed by the SCCB master, not by the sequencer itself.
package ov7670_config_seq_pkg;

  localparam logic [15:0] SENTINEL_END   = 16'hFFFF;
  localparam logic [15:0] SENTINEL_DELAY = 16'hFFF0;
  localparam logic [7:0]  SCCB_WRITE_ID  = 8'h42;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_SEND,
    ST_WAIT,
    ST_DELAY,
    ST_NEXT,
    ST_FINISH,
    ST_FAIL
  } cfg_state_t;

  // Cycles spent in one delay entry for a given clock rate and delay length.
  function automatic int delay_cycles(input int clk_hz, input int delay_ms);
    return clk_hz / 1000 * delay_ms;
  endfunction

endpackage

// File: rtl/ov7670_config_seq_if.sv
// SCCB write-command channel between the config sequencer (master) and the SCCB master (slave).
interface ov7670_config_seq_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_data;
  logic       cmd_done;
  logic       cmd_nack;

  modport master (
    output cmd_valid,
    output cmd_reg,
    output cmd_data,
    input  cmd_ready,
    input  cmd_done,
    input  cmd_nack
  );

  modport slave (
    input  cmd_valid,
    input  cmd_reg,
    input  cmd_data,
    output cmd_ready,
    output cmd_done,
    output cmd_nack
  );

endinterface

// File: rtl/ov7670_config_seq_delay_timer.sv
// Loadable down-counter with a zero flag; used for timed delay entries and post-reset waits.
module cfg_delay_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ov7670_config_seq.sv
// Walks the OV7670 init ROM from address 0, issuing each {reg,value} entry as an SCCB write
// and honouring the delay (FFF0) and end-of-table (FFFF) sentinels.
module ov7670_config_seq
  import ov7670_config_seq_pkg::*;
#(
  parameter int CLK_HZ      = 25_000_000,
  parameter int DELAY_MS    = 10,
  parameter int MAX_RETRY   = 3,
  parameter int MAX_ENTRIES = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic [7:0]                  rom_addr,
  input  logic [15:0]                 rom_dout,
  ov7670_config_seq_if.master         cmd,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

  localparam int DLY_CYC = delay_cycles(CLK_HZ, DELAY_MS);
  localparam int DLY_W   = $clog2(DLY_CYC) + 1;
  localparam int RTRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [DLY_W-1:0]  DLY_LOAD  = DLY_W'(DLY_CYC - 1);
  localparam logic [RTRY_W-1:0] RTRY_MAX  = RTRY_W'(MAX_RETRY);
  localparam logic [7:0]        LAST_ADDR = 8'(MAX_ENTRIES - 1);

  cfg_state_t        state;
  logic [RTRY_W-1:0] retry;
  logic              dly_load;
  logic              dly_en;
  logic              dly_zero;

  // The timer is loaded while the delay sentinel sits on the ROM output, so the first
  // DELAY cycle already sees DLY_CYC-1 and the state lasts exactly DLY_CYC cycles.
  assign dly_load = (state == ST_DECODE) && (rom_dout == SENTINEL_DELAY);
  assign dly_en   = (state == ST_DELAY);

  cfg_delay_timer #(
    .W (DLY_W)
  ) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dly_load),
    .load_val (DLY_LOAD),
    .en       (dly_en),
    .zero     (dly_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rom_addr      <= '0;
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_reg   <= '0;
      cmd.cmd_data  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      retry         <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            rom_addr <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_FETCH;
          end
        end

        ST_FETCH: state <= ST_DECODE;

        ST_DECODE: begin
          if (rom_dout == SENTINEL_END) begin
            state <= ST_FINISH;
          end else if (rom_dout == SENTINEL_DELAY) begin
            state <= ST_DELAY;
          end else begin
            cmd.cmd_reg   <= rom_dout[15:8];
            cmd.cmd_data  <= rom_dout[7:0];
            cmd.cmd_valid <= 1'b1;
            retry         <= '0;
            state         <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (cmd.cmd_valid && cmd.cmd_ready) begin
            cmd.cmd_valid <= 1'b0;
            state         <= ST_WAIT;
          end
        end

        // A NACKed transfer is re-issued with the same reg/data until retries run out.
        ST_WAIT: begin
          if (cmd.cmd_done) begin
            if (!cmd.cmd_nack) begin
              state <= ST_NEXT;
            end else if (retry < RTRY_MAX) begin
              retry         <= retry + 1'b1;
              cmd.cmd_valid <= 1'b1;
              state         <= ST_SEND;
            end else begin
              state <= ST_FAIL;
            end
          end
        end

        ST_DELAY: begin
          if (dly_zero) state <= ST_NEXT;
        end

        // The address never wraps: running off the end without a terminator is an error.
        ST_NEXT: begin
          if (rom_addr == LAST_ADDR) begin
            state <= ST_FAIL;
          end else begin
            rom_addr <= rom_addr + 8'd1;
            state    <= ST_FETCH;
          end
        end

        ST_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        ST_FAIL: begin
          error <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Scoreboard bench for ov7670_config_seq: ROM model, SCCB slave model and write monitor.
module tb_ov7670_config_seq;

  // Small clock so one delay entry lasts 100 cycles.
  localparam int CLK_HZ   = 100_000;
  localparam int DELAY_MS = 1;
  // Accept of write 0 to accept of write 1 across a delay entry:
  // 2 (done) + NEXT,FETCH,DECODE (3) + 100 DELAY + NEXT,FETCH,DECODE,SEND (4) = 109.
  localparam int GAP_EXP  = 109;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_dout;
  logic        busy, done, error;
  logic [15:0] rom_mem [256];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_acc = 0;
  int          cyc   = 0;
  int          acc_t[$];
  logic [15:0] exp_q[$];
  int          nack_addr = -1;
  int          nack_left = 0;
  bit          nack_all  = 1'b0;

  ov7670_config_seq_if cmd_if ();

  ov7670_config_seq #(
    .CLK_HZ      (CLK_HZ),
    .DELAY_MS    (DELAY_MS),
    .MAX_RETRY   (3),
    .MAX_ENTRIES (256)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .cmd      (cmd_if),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    rom_dout = rom_mem[rom_addr];
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted write is popped against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
      n_acc++;
      acc_t.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got %02h/%02h, expected none",
                 cmd_if.cmd_reg, cmd_if.cmd_data);
      end else begin
        chk("write", {16'h0, cmd_if.cmd_reg, cmd_if.cmd_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // SCCB slave model: completion pulse 2 cycles after accept, NACK per test plan.
  initial forever begin
    bit nk;
    @(negedge clk);
    if (rst_n && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
      nk = 1'b0;
      if (int'(rom_addr) == nack_addr) begin
        if (nack_all) nk = 1'b1;
        else if (nack_left > 0) begin
          nk = 1'b1;
          nack_left--;
        end
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      cmd_if.cmd_done = 1'b1;
      cmd_if.cmd_nack = nk;
      @(posedge clk);
      #1;
      cmd_if.cmd_done = 1'b0;
      cmd_if.cmd_nack = 1'b0;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int k = 0;
    while (busy !== 1'b0 && k < maxc) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk({nm, "_in_time"}, 32'(k < maxc), 32'd1);
  endtask

  task automatic wait_acc(input int n, input int maxc);
    int k = 0;
    while (n_acc < n && k < maxc) begin
      @(posedge clk);
      k++;
    end
    chk("accept_in_time", 32'(k < maxc), 32'd1);
  endtask

  task automatic load_tbl(input logic [15:0] t[$]);
    for (int i = 0; i < 256; i++) rom_mem[i] = (i < t.size()) ? t[i] : 16'hFFFF;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk(nm, {busy, done, error, cmd_if.cmd_valid, rom_addr, cmd_if.cmd_reg, cmd_if.cmd_data},
        32'h0);
  endtask

  initial begin
    int gap, stable;
    rst_n = 1'b0;
    start = 1'b0;
    cmd_if.cmd_ready = 1'b1;
    cmd_if.cmd_done  = 1'b0;
    cmd_if.cmd_nack  = 1'b0;
    load_tbl('{16'h1280, 16'hFFF0, 16'h1214, 16'hFFFF});
    repeat (3) @(posedge clk);
    #1 chk_reset_outs("reset_outputs");
    rst_n = 1'b1;

    // 1: two writes separated by one delay entry
    exp_q = '{16'h1280, 16'h1214};
    n_acc = 0; acc_t.delete();
    pulse_start();
    chk("t1_busy_after_start", 32'(busy), 32'd1);
    wait_idle(600, "t1");
    chk("t1_flags", {29'h0, busy, done, error}, 32'b010);
    chk("t1_accepts", n_acc, 2);
    gap = (acc_t.size() == 2) ? acc_t[1] - acc_t[0] : -1;
    chk("t1_delay_gap", gap, GAP_EXP);
    chk("t1_queue_left", exp_q.size(), 0);

    // 2: back-pressure holds request and payload stable
    load_tbl('{16'h3A04, 16'hFFFF});
    exp_q = '{16'h3A04};
    n_acc = 0;
    cmd_if.cmd_ready = 1'b0;
    pulse_start();
    chk("t2_done_cleared", 32'(done), 32'd0);
    for (int k = 0; k < 50 && !cmd_if.cmd_valid; k++) begin
      @(posedge clk); #1;
    end
    stable = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (cmd_if.cmd_valid && cmd_if.cmd_reg == 8'h3A && cmd_if.cmd_data == 8'h04) stable++;
    end
    chk("t2_held_cycles", stable, 20);
    cmd_if.cmd_ready = 1'b1;
    wait_idle(100, "t2");
    chk("t2_accepts", n_acc, 1);
    chk("t2_flags", {29'h0, busy, done, error}, 32'b010);

    // 3: entry 3 NACKed twice then acknowledged
    load_tbl('{16'h1280, 16'h1101, 16'h6B0A, 16'h3A04, 16'hFFFF});
    exp_q = '{16'h1280, 16'h1101, 16'h6B0A, 16'h3A04, 16'h3A04, 16'h3A04};
    n_acc = 0; nack_addr = 3; nack_left = 2; nack_all = 1'b0;
    pulse_start();
    wait_idle(200, "t3");
    chk("t3_accepts", n_acc, 6);
    chk("t3_flags", {29'h0, busy, done, error}, 32'b010);

    // 4: permanent NACK exhausts retries on entry 0
    load_tbl('{16'h1280, 16'h1101, 16'hFFFF});
    exp_q = '{16'h1280, 16'h1280, 16'h1280, 16'h1280};
    n_acc = 0; nack_addr = 0; nack_all = 1'b1;
    pulse_start();
    wait_idle(200, "t4");
    chk("t4_accepts", n_acc, 4);
    chk("t4_flags", {29'h0, busy, done, error}, 32'b001);
    nack_all = 1'b0; nack_addr = -1;

    // 5: no terminator anywhere in the address space
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'h1180;
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(16'h1180);
    n_acc = 0;
    pulse_start();
    wait_idle(4000, "t5");
    chk("t5_accepts", n_acc, 256);
    chk("t5_flags", {29'h0, busy, done, error}, 32'b001);
    chk("t5_rom_addr", 32'(rom_addr), 32'd255);

    // 6a: reset during DELAY, then clean rerun ignoring a mid-run start
    load_tbl('{16'h1280, 16'hFFF0, 16'h1214, 16'hFFFF});
    exp_q = '{16'h1280, 16'h1214};
    n_acc = 0;
    pulse_start();
    wait_acc(1, 50);
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_outs("t6_reset_in_delay");
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q = '{16'h1280, 16'h1214};
    n_acc = 0;
    pulse_start();
    repeat (5) @(posedge clk);
    pulse_start();
    wait_idle(600, "t6a");
    chk("t6a_accepts", n_acc, 2);
    chk("t6a_flags", {29'h0, busy, done, error}, 32'b010);

    // 6b: reset while waiting for transfer completion
    exp_q = '{16'h1280};
    n_acc = 0;
    pulse_start();
    wait_acc(1, 50);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("t6_reset_in_wait");
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q = '{16'h1280, 16'h1214};
    n_acc = 0;
    pulse_start();
    wait_idle(600, "t6b");
    chk("t6b_accepts", n_acc, 2);
    chk("t6b_flags", {29'h0, busy, done, error}, 32'b010);
    chk("t6b_queue_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
